// File: rtl/sysbus_arbiter_if.sv
// One Sysbus port: request beats toward the bus, response beats back from it.
interface sysbus_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
);
  logic              reqcyc;
  logic [DATA_W-1:0] req;
  logic [TAG_W-1:0]  reqtag;
  logic              reqack;
  logic              respcyc;
  logic [DATA_W-1:0] resp;
  logic [TAG_W-1:0]  resptag;
  logic              respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter sharing one Sysbus master between fetch (m0) and data (m1) for whole line transactions.
// Grant takes one idle cycle; beats pass through combinationally, and each side's ack/backpressure is forwarded unchanged.
module sysbus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input logic            clk,
  input logic            reset,
  sysbus_arbiter_if.slave  m0,
  sysbus_arbiter_if.slave  m1,
  sysbus_arbiter_if.master bus
);
  localparam int CW = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_owner, w_owner_nxt;
  logic            r_last_grant, w_last_grant_nxt;
  logic            r_is_read, w_is_read_nxt;
  logic [CW-1:0]   r_beat_cnt, w_beat_cnt_nxt;

  logic                      w_own_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] w_own_req;
  logic [BUS_TAG_WIDTH-1:0]  w_own_reqtag;
  logic                      w_own_respack;
  logic                      w_req_fire;
  logic                      w_resp_fire;

  assign w_own_reqcyc  = r_owner ? m1.reqcyc  : m0.reqcyc;
  assign w_own_req     = r_owner ? m1.req     : m0.req;
  assign w_own_reqtag  = r_owner ? m1.reqtag  : m0.reqtag;
  assign w_own_respack = r_owner ? m1.respack : m0.respack;
  assign w_req_fire    = w_own_reqcyc & bus.reqack;
  assign w_resp_fire   = bus.respcyc & w_own_respack;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_is_read    <= 1'b0;
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_is_read    <= w_is_read_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_is_read_nxt    = r_is_read;
    w_beat_cnt_nxt   = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (m0.reqcyc | m1.reqcyc) begin
          // On a tie the port that did not win last time takes the bus.
          w_owner_nxt      = (m0.reqcyc & m1.reqcyc) ? ~r_last_grant : m1.reqcyc;
          w_last_grant_nxt = w_owner_nxt;
          w_beat_cnt_nxt   = '0;
          w_state_nxt      = REQ;
        end
      end
      REQ: begin
        if (!w_own_reqcyc) begin
          w_state_nxt = IDLE;
        end else if (bus.reqack) begin
          w_is_read_nxt = w_own_reqtag[BUS_TAG_WIDTH-1];
          w_state_nxt   = w_own_reqtag[BUS_TAG_WIDTH-1] ? RESP : WDATA;
        end
      end
      WDATA: begin
        if (w_req_fire) begin
          if (r_beat_cnt == LAST_BEAT) w_state_nxt = IDLE;
          else                         w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        end
      end
      RESP: begin
        if (w_resp_fire) begin
          if (r_beat_cnt == LAST_BEAT) w_state_nxt = IDLE;
          else                         w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.reqcyc  = 1'b0;
    bus.req     = '0;
    bus.reqtag  = '0;
    bus.respack = 1'b0;
    m0.reqack   = 1'b0;
    m0.respcyc  = 1'b0;
    m0.resp     = '0;
    m0.resptag  = '0;
    m1.reqack   = 1'b0;
    m1.respcyc  = 1'b0;
    m1.resp     = '0;
    m1.resptag  = '0;
    if (r_state == REQ || r_state == WDATA) begin
      bus.reqcyc = w_own_reqcyc;
      bus.req    = w_own_req;
      bus.reqtag = w_own_reqtag;
      if (r_owner) m1.reqack = bus.reqack;
      else         m0.reqack = bus.reqack;
    end
    // Response beats are only routed while the owner's read is outstanding.
    if (r_state == RESP && r_is_read) begin
      bus.respack = w_own_respack;
      if (r_owner) begin
        m1.respcyc = bus.respcyc;
        m1.resp    = bus.resp;
        m1.resptag = bus.resptag;
      end else begin
        m0.respcyc = bus.respcyc;
        m0.resp    = bus.resp;
        m0.resptag = bus.resptag;
      end
    end
  end
endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter: control-bit vector table, multi-cycle sequences, then random traffic against a transaction model.
module tb_sysbus_arbiter;
  localparam int DW = 64;
  localparam int TW = 13;
  localparam int BEATS = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sysbus_arbiter_if #(.DATA_W(DW), .TAG_W(TW)) m0_if ();
  sysbus_arbiter_if #(.DATA_W(DW), .TAG_W(TW)) m1_if ();
  sysbus_arbiter_if #(.DATA_W(DW), .TAG_W(TW)) bus_if ();

  sysbus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(BEATS)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .bus   (bus_if)
  );

  typedef struct packed {
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_respack;
    logic          m0_reqack;
    logic          m0_respcyc;
    logic [DW-1:0] m0_resp;
    logic [TW-1:0] m0_resptag;
    logic          m1_reqack;
    logic          m1_respcyc;
    logic [DW-1:0] m1_resp;
    logic [TW-1:0] m1_resptag;
  } out_t;

  // Inputs {rst r0 r1 bra brc ra0 ra1}, expected {bus_reqcyc m0_reqack m1_reqack m0_respcyc m1_respcyc bus_respack}.
  typedef struct packed {
    logic [6:0] in;
    logic [5:0] exp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  function automatic vec_t v(input logic [6:0] in, input logic [5:0] e);
    vec_t r;
    r.in  = in;
    r.exp = e;
    return r;
  endfunction

  function automatic out_t sample();
    out_t s;
    s.bus_reqcyc  = bus_if.reqcyc;
    s.bus_req     = bus_if.req;
    s.bus_reqtag  = bus_if.reqtag;
    s.bus_respack = bus_if.respack;
    s.m0_reqack   = m0_if.reqack;
    s.m0_respcyc  = m0_if.respcyc;
    s.m0_resp     = m0_if.resp;
    s.m0_resptag  = m0_if.resptag;
    s.m1_reqack   = m1_if.reqack;
    s.m1_respcyc  = m1_if.respcyc;
    s.m1_resp     = m1_if.resp;
    s.m1_resptag  = m1_if.resptag;
    return s;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    reset = 1'b1;
    m0_if.reqcyc = 0; m0_if.req = '0; m0_if.reqtag = '0; m0_if.respack = 0;
    m1_if.reqcyc = 0; m1_if.req = '0; m1_if.reqtag = '0; m1_if.respack = 0;
    bus_if.reqack = 0; bus_if.respcyc = 0; bus_if.resp = '0; bus_if.resptag = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: what is left to move in the current grant.
  bit mb_busy, mb_own, mb_last, mb_hdr;
  int mb_req_left, mb_resp_left;

  function automatic out_t model_out();
    out_t e = '0;
    bit pass = mb_busy && mb_req_left > 0;
    bit rsp  = mb_busy && mb_req_left == 0 && mb_resp_left > 0;
    if (pass) begin
      e.bus_reqcyc = mb_own ? m1_if.reqcyc : m0_if.reqcyc;
      e.bus_req    = mb_own ? m1_if.req    : m0_if.req;
      e.bus_reqtag = mb_own ? m1_if.reqtag : m0_if.reqtag;
      if (mb_own) e.m1_reqack = bus_if.reqack;
      else        e.m0_reqack = bus_if.reqack;
    end
    if (rsp) begin
      e.bus_respack = mb_own ? m1_if.respack : m0_if.respack;
      if (mb_own) begin
        e.m1_respcyc = bus_if.respcyc; e.m1_resp = bus_if.resp; e.m1_resptag = bus_if.resptag;
      end else begin
        e.m0_respcyc = bus_if.respcyc; e.m0_resp = bus_if.resp; e.m0_resptag = bus_if.resptag;
      end
    end
    return e;
  endfunction

  task automatic model_step();
    bit r0 = m0_if.reqcyc, r1 = m1_if.reqcyc;
    bit orc = mb_own ? r1 : r0;
    logic [TW-1:0] otag = mb_own ? m1_if.reqtag : m0_if.reqtag;
    bit orack = mb_own ? m1_if.respack : m0_if.respack;
    if (!reset) begin
      mb_busy = 0; mb_last = 1;
    end else if (!mb_busy) begin
      if (r0 || r1) begin
        mb_own = (r0 && r1) ? !mb_last : r1;
        mb_last = mb_own;
        mb_busy = 1; mb_hdr = 1; mb_req_left = 1; mb_resp_left = 0;
      end
    end else if (mb_req_left > 0) begin
      if (mb_hdr && !orc) mb_busy = 0;
      else if (orc && bus_if.reqack) begin
        mb_req_left--;
        if (mb_hdr) begin
          mb_hdr = 0;
          if (otag[TW-1]) mb_resp_left = BEATS;
          else            mb_req_left  = BEATS;
        end
        if (mb_req_left == 0 && mb_resp_left == 0) mb_busy = 0;
      end
    end else if (mb_resp_left > 0) begin
      if (bus_if.respcyc && orack) begin
        mb_resp_left--;
        if (mb_resp_left == 0) mb_busy = 0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] exp_data;
    int acc;
    bit d_act[2];
    int d_left[2];
    logic [DW-1:0] d_req[2];
    logic [TW-1:0] d_tag[2];
    out_t e;

    // rst r0 r1 bra brc ra0 ra1 | bcyc a0 a1 rc0 rc1 brack
    tbl.push_back(v(7'b0000000, 6'b000000));
    tbl.push_back(v(7'b1000000, 6'b000000));
    tbl.push_back(v(7'b1100000, 6'b000000));              // arbitration cycle
    repeat (2) tbl.push_back(v(7'b1100000, 6'b100000));   // bus stalls header
    tbl.push_back(v(7'b1101000, 6'b110000));
    for (int b = 0; b < BEATS; b++) begin
      if (b == 3) tbl.push_back(v(7'b1000101, 6'b000100)); // m0 stalls, m1 respack ignored
      tbl.push_back(v(7'b1000110, 6'b000101));
    end
    tbl.push_back(v(7'b1000110, 6'b000000));              // spurious response in IDLE
    tbl.push_back(v(7'b0000000, 6'b000000));
    tbl.push_back(v(7'b1110000, 6'b000000));              // tie after reset
    tbl.push_back(v(7'b1111000, 6'b110000));
    repeat (BEATS) tbl.push_back(v(7'b1010110, 6'b000101));
    tbl.push_back(v(7'b1010000, 6'b000000));
    tbl.push_back(v(7'b1011000, 6'b101000));
    repeat (4) tbl.push_back(v(7'b1100110, 6'b000010));   // m1 respack low: frozen
    repeat (BEATS) tbl.push_back(v(7'b1100101, 6'b000011));
    tbl.push_back(v(7'b1110000, 6'b000000));              // tie again: m0 this time
    tbl.push_back(v(7'b1111000, 6'b110000));
    repeat (BEATS) tbl.push_back(v(7'b1010110, 6'b000101));
    tbl.push_back(v(7'b1000000, 6'b000000));
    tbl.push_back(v(7'b1100000, 6'b000000));
    tbl.push_back(v(7'b1000000, 6'b000000));              // m0 drops before ack
    tbl.push_back(v(7'b1011000, 6'b000000));              // back in IDLE: ack ignored
    tbl.push_back(v(7'b1011000, 6'b101000));
    tbl.push_back(v(7'b0000000, 6'b000000));              // reset while in RESP

    clr_in();
    reset = 1'b0;
    tick();
    for (int i = 0; i < tbl.size(); i++) begin
      {reset, m0_if.reqcyc, m1_if.reqcyc, bus_if.reqack, bus_if.respcyc,
       m0_if.respack, m1_if.respack} = tbl[i].in;
      m0_if.req = 64'h1000; m0_if.reqtag = 13'h1100;
      m1_if.req = 64'h3000; m1_if.reqtag = 13'h1200;
      bus_if.resp = DW'(i); bus_if.resptag = 13'h1100;
      @(negedge clk);
      chk($sformatf("tbl[%0d]", i),
          {bus_if.reqcyc, m0_if.reqack, m1_if.reqack, m0_if.respcyc, m1_if.respcyc, bus_if.respack},
          tbl[i].exp);
      tick();
    end

    // m1 write with the bus accepting every other cycle.
    clr_in();
    m1_if.reqcyc = 1; m1_if.req = 64'h2000; m1_if.reqtag = 13'h0055;
    @(negedge clk);
    chk("wr_arb", bus_if.reqcyc, 0);
    tick();
    acc = 0;
    for (int c = 0; c < 40 && acc < BEATS + 1; c++) begin
      bus_if.reqack = c[0];
      exp_data = (acc == 0) ? 64'h2000 : 64'hD0 + DW'(acc - 1);
      @(negedge clk);
      chk("wr_reqcyc", bus_if.reqcyc, 1);
      chk("wr_req", bus_if.req, exp_data);
      chk("wr_tag", bus_if.reqtag, 13'h0055);
      chk("wr_ack", m1_if.reqack, c[0]);
      tick();
      if (c[0]) begin
        acc++;
        m1_if.req = 64'hD0 + DW'(acc - 1);
        if (acc == BEATS + 1) m1_if.reqcyc = 0;
      end
    end
    chk("wr_beats", acc, BEATS + 1);
    bus_if.reqack = 0; bus_if.respcyc = 1; m1_if.respack = 1;
    @(negedge clk);
    chk("wr_idle", sample(), '0);
    tick();

    // m0 read abandoned by reset at beat 4, then a fresh m1 read.
    clr_in();
    reset = 0;
    tick();
    reset = 1; m0_if.reqcyc = 1; m0_if.req = 64'h1000; m0_if.reqtag = 13'h1100;
    tick();
    bus_if.reqack = 1;
    @(negedge clk);
    chk("rd_req", bus_if.req, 64'h1000);
    chk("rd_ack", m0_if.reqack, 1);
    tick();
    m0_if.reqcyc = 0; bus_if.reqack = 0; bus_if.respcyc = 1; m0_if.respack = 1;
    for (int b = 0; b < 5; b++) begin
      bus_if.resp = DW'(b);
      if (b == 4) reset = 0;
      @(negedge clk);
      chk($sformatf("rd_beat%0d", b), {m0_if.respcyc, m0_if.resp, m1_if.respcyc}, {1'b1, DW'(b), 1'b0});
      tick();
    end
    reset = 1;
    @(negedge clk);
    chk("rst_outputs", sample(), '0);
    tick();
    bus_if.respcyc = 0; m0_if.respack = 0;
    m1_if.reqcyc = 1; m1_if.req = 64'h4000; m1_if.reqtag = 13'h1abc;
    @(negedge clk);
    chk("m1_arb", sample(), '0);
    tick();
    bus_if.reqack = 1;
    @(negedge clk);
    chk("m1_req", {bus_if.req, m1_if.reqack, m0_if.reqack}, {64'h4000, 1'b1, 1'b0});
    tick();
    m1_if.reqcyc = 0; bus_if.reqack = 0; bus_if.respcyc = 1; m1_if.respack = 1;
    for (int b = 0; b < BEATS; b++) begin
      bus_if.resp = 64'd100 + DW'(b);
      @(negedge clk);
      chk($sformatf("m1_beat%0d", b), {m1_if.respcyc, m1_if.resp, bus_if.respack},
          {1'b1, 64'd100 + DW'(b), 1'b1});
      tick();
    end
    @(negedge clk);
    chk("m1_idle", sample(), '0);
    tick();

    // Random traffic; requesters hold reqcyc until acked and send 1 (read) or 9 (write) beats.
    mb_busy = 0; mb_last = 1; mb_own = 0; mb_hdr = 0; mb_req_left = 0; mb_resp_left = 0;
    for (int p = 0; p < 2; p++) begin
      d_act[p] = 0; d_left[p] = 0; d_req[p] = '0; d_tag[p] = '0;
    end
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!d_act[p] && $urandom_range(3) == 0) begin
          d_act[p]  = 1;
          d_tag[p]  = TW'($urandom);
          d_left[p] = d_tag[p][TW-1] ? 1 : BEATS + 1;
          d_req[p]  = {$urandom, $urandom};
        end
      end
      reset = (n == 0) ? 1'b0 : ($urandom_range(199) != 0);
      m0_if.reqcyc = d_act[0]; m0_if.req = d_req[0]; m0_if.reqtag = d_tag[0];
      m1_if.reqcyc = d_act[1]; m1_if.req = d_req[1]; m1_if.reqtag = d_tag[1];
      m0_if.respack = 1'($urandom); m1_if.respack = 1'($urandom);
      bus_if.reqack = 1'($urandom);
      bus_if.respcyc = ($urandom_range(2) != 0);
      bus_if.resp = {$urandom, $urandom}; bus_if.resptag = TW'($urandom);
      @(negedge clk);
      e = model_out();
      chk($sformatf("rand[%0d]", n), sample(), e);
      for (int p = 0; p < 2; p++) begin
        if (d_act[p] && (p == 0 ? e.m0_reqack : e.m1_reqack)) begin
          d_left[p]--;
          d_req[p] = {$urandom, $urandom};
          if (d_left[p] == 0) d_act[p] = 0;
        end
        if (!reset) d_act[p] = 0;
      end
      model_step();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
